decode_imm_ctrl: RTL and testbench



---
 rtl/decode_imm_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_decode_imm_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_imm_ctrl.sv
// Decode-stage controller: two-entry skid buffer in front of an external immediate
// generator, with load-use bubble insertion and flush handling toward execute.
module decode_imm_ctrl #(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            ex_load_valid,
  input  logic [4:0]      ex_rd,
  output logic [2:0]      gen_ImmType,
  output logic [XLEN-1:0] gen_instr,
  input  logic [XLEN-1:0] gen_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  buf_state_t state_q, state_d;

  logic [XLEN-1:0] head_instr_q, head_pc_q;
  logic [XLEN-1:0] skid_instr_q, skid_pc_q;

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  logic [2:0] imm_type;
  logic       imm_zero;
  logic       dec_illegal;
  logic       uses_rs1;
  logic       uses_rs2;

  logic head_present;
  logic out_free;
  logic hazard;
  logic accept;
  logic pop;
  logic bubble;

  assign opcode = head_instr_q[6:0];
  assign rs1    = head_instr_q[19:15];
  assign rs2    = head_instr_q[24:20];

  // Opcode decode of the head entry; R-type and unknown opcodes carry no immediate.
  always_comb begin
    imm_type    = IMM_I;
    imm_zero    = 1'b0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b1;
    uses_rs2    = 1'b0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: imm_type = IMM_I;
      7'b0100011: begin
        imm_type = IMM_S;
        uses_rs2 = 1'b1;
      end
      7'b1100011: begin
        imm_type = IMM_B;
        uses_rs2 = 1'b1;
      end
      7'b0110111, 7'b0010111: begin
        imm_type = IMM_U;
        uses_rs1 = 1'b0;
      end
      7'b1101111: begin
        imm_type = IMM_J;
        uses_rs1 = 1'b0;
      end
      7'b0110011: begin
        imm_zero = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: begin
        imm_zero    = 1'b1;
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign gen_ImmType = imm_type;
  assign gen_instr   = head_instr_q;

  assign head_present = (state_q != EMPTY);
  assign out_free     = !out_valid || out_ready;
  assign hazard       = head_present && ex_load_valid && (ex_rd != 5'd0) &&
                        ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
  assign accept       = in_valid && in_ready && !flush;
  assign pop          = out_free && head_present && !hazard && !flush;
  assign bubble       = out_free && hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY:   if (accept) state_d = ONE;
        ONE: begin
          if (accept && !pop) state_d = TWO;
          else if (pop && !accept) state_d = EMPTY;
        end
        TWO:     if (pop) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready is a flop so fetch never sees a combinational path from execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready <= 1'b1;
    end else begin
      in_ready <= (state_d != TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_instr_q <= '0;
      head_pc_q    <= '0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else if (!flush) begin
      if (accept && ((state_q == EMPTY) || ((state_q == ONE) && pop))) begin
        head_instr_q <= in_instr;
        head_pc_q    <= in_pc;
      end else if (pop && (state_q == TWO)) begin
        head_instr_q <= skid_instr_q;
        head_pc_q    <= skid_pc_q;
      end
      if (accept && (state_q == ONE) && !pop) begin
        skid_instr_q <= in_instr;
        skid_pc_q    <= in_pc;
      end
    end
  end

  // A bubble keeps the stalled instruction's PC; only the NOP encoding matters downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_instr   <= NOP_INSTR;
      out_pc      <= '0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (pop) begin
      out_valid   <= 1'b1;
      out_instr   <= head_instr_q;
      out_pc      <= head_pc_q;
      out_imm     <= imm_zero ? '0 : gen_imm;
      out_illegal <= dec_illegal;
    end else if (bubble) begin
      out_valid   <= 1'b1;
      out_instr   <= NOP_INSTR;
      out_pc      <= head_pc_q;
      out_imm     <= '0;
      out_illegal <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_imm_ctrl.sv
// Randomized and directed bench for decode_imm_ctrl, checked against a queue-based
// model of the decode stage; the bench also plays the immediate generator.
module tb_decode_imm_ctrl;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        ex_load_valid = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic [2:0]  gen_ImmType;
  logic [31:0] gen_instr;
  logic [31:0] gen_imm;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic        out_illegal;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  logic        m_valid;
  logic [31:0] m_instr, m_pc, m_imm;
  logic        m_illegal, m_bubble;

  logic [6:0] opc_tab [12] = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63,
                               7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F, 7'h00};

  decode_imm_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .ex_load_valid(ex_load_valid), .ex_rd(ex_rd),
    .gen_ImmType(gen_ImmType), .gen_instr(gen_instr), .gen_imm(gen_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_imm(out_imm), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_gen(input logic [31:0] i, input logic [2:0] t);
    case (t)
      3'd0:    return {{20{i[31]}}, i[31:20]};
      3'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    return {i[31:12], 12'h000};
      3'd4:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  assign gen_imm = ref_gen(gen_instr, gen_ImmType);

  function automatic logic [2:0] exp_type(input logic [31:0] i);
    case (i[6:0])
      7'h23:        return 3'd1;
      7'h63:        return 3'd2;
      7'h37, 7'h17: return 3'd3;
      7'h6F:        return 3'd4;
      default:      return 3'd0;
    endcase
  endfunction

  function automatic logic exp_illegal(input logic [31:0] i);
    case (i[6:0])
      7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] i);
    if (i[6:0] == 7'h33 || exp_illegal(i)) return 32'h0;
    return ref_gen(i, exp_type(i));
  endfunction

  function automatic logic reads_reg(input logic [31:0] i, input logic [4:0] rd);
    logic r1, r2;
    r1 = !(i[6:0] inside {7'h37, 7'h17, 7'h6F}) && (i[19:15] == rd);
    r2 = (i[6:0] inside {7'h23, 7'h63, 7'h33}) && (i[24:20] == rd);
    return r1 || r2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_instr.delete();
    q_pc.delete();
    m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_imm = '0;
    m_illegal = 1'b0; m_bubble = 1'b0;
  endtask

  // One clock: drive inputs, advance the model, then compare registered outputs.
  task automatic applyStimulus(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                               input logic fl, input logic lv, input logic [4:0] rd,
                               input logic ordy);
    logic ready, free, haz;
    in_valid = iv; in_instr = instr; in_pc = pc; flush = fl;
    ex_load_valid = lv; ex_rd = rd; out_ready = ordy;
    #1;
    if (q_instr.size() > 0) begin
      checkOutput("gen_ImmType", {29'd0, gen_ImmType}, {29'd0, exp_type(q_instr[0])});
      checkOutput("gen_instr", gen_instr, q_instr[0]);
    end
    ready = (q_instr.size() < 2);
    if (fl) begin
      q_instr.delete();
      q_pc.delete();
      m_valid = 1'b0;
    end else begin
      free = !m_valid || ordy;
      haz  = (q_instr.size() > 0) && lv && (rd != 5'd0) && reads_reg(q_instr[0], rd);
      if (free && q_instr.size() > 0 && !haz) begin
        m_valid = 1'b1; m_bubble = 1'b0;
        m_instr = q_instr[0]; m_pc = q_pc[0];
        m_imm = exp_imm(q_instr[0]); m_illegal = exp_illegal(q_instr[0]);
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end else if (free && haz) begin
        m_valid = 1'b1; m_bubble = 1'b1;
        m_instr = NOP; m_imm = '0; m_illegal = 1'b0;
      end else if (ordy) begin
        m_valid = 1'b0;
      end
      if (iv && ready) begin
        q_instr.push_back(instr);
        q_pc.push_back(pc);
      end
    end
    @(posedge clk);
    #1;
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, q_instr.size() < 2});
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid) begin
      checkOutput("out_instr", out_instr, m_instr);
      checkOutput("out_imm", out_imm, m_imm);
      checkOutput("out_illegal", {31'd0, out_illegal}, {31'd0, m_illegal});
      if (!m_bubble) checkOutput("out_pc", out_pc, m_pc);
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, ordy);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    i = $urandom;
    i[6:0]   = opc_tab[$urandom_range(0, 11)];
    i[19:15] = 5'($urandom_range(0, 3));
    i[24:20] = 5'($urandom_range(0, 3));
    return i;
  endfunction

  logic [31:0] imm_stream [5] = '{32'hFFF00093, 32'h0020A423, 32'hFE000EE3,
                                  32'h123452B7, 32'h001000EF};

  initial begin
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 5; k++)
      applyStimulus(1'b1, imm_stream[k], 32'h100 + 32'(4 * k), 1'b0, 1'b0, 5'd0, 1'b1);
    idle(2, 1'b1);

    // Backpressure: three instructions offered while execute stalls.
    for (int k = 0; k < 4; k++)
      applyStimulus(k < 3, 32'h00100093 + 32'(k << 20), 32'h200 + 32'(4 * k),
                    1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h00300093, 32'h208, 1'b0, 1'b0, 5'd0, 1'b0);
    idle(4, 1'b1);

    // Load-use on x1, then the same with ex_rd = 0.
    applyStimulus(1'b1, 32'h00108133, 32'h300, 1'b0, 1'b1, 5'd1, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 1'b1);
    idle(2, 1'b1);
    applyStimulus(1'b1, 32'h00108133, 32'h304, 1'b0, 1'b1, 5'd0, 1'b1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 1'b1);
    idle(2, 1'b1);

    // Fill to two entries, then flush with a colliding fetch.
    applyStimulus(1'b1, 32'h00500093, 32'h400, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h00600093, 32'h404, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h00700093, 32'h408, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h00800093, 32'h40C, 1'b1, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b1, 32'h00900093, 32'h500, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(2, 1'b1);

    applyStimulus(1'b1, 32'h0000007F, 32'h600, 1'b0, 1'b0, 5'd0, 1'b1);
    applyStimulus(1'b1, 32'h002081B3, 32'h604, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(2, 1'b1);

    for (int k = 0; k < 800; k++)
      applyStimulus($urandom_range(0, 3) != 0, rand_instr(), $urandom,
                    $urandom_range(0, 15) == 0, $urandom_range(0, 2) == 0,
                    5'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);

    // Asynchronous reset mid-stream with entries buffered.
    applyStimulus(1'b1, 32'h00A00093, 32'h700, 1'b0, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b1, 32'h00B00093, 32'h704, 1'b0, 1'b0, 5'd0, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_out_instr", out_instr, NOP);
    checkOutput("rst_out_pc", out_pc, 32'd0);
    checkOutput("rst_out_imm", out_imm, 32'd0);
    checkOutput("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 32'h00C00093, 32'h800, 1'b0, 1'b0, 5'd0, 1'b1);
    idle(3, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
